// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl: keyboard-driven PWM level controller.
// Two raw push-buttons are synchronised, debounced and turned into level
// requests. Each request is parked in a one-deep pending flag and committed
// only at a PWM period boundary, so the duty level steps at most once per
// period. One-cycle inc_o/dec_o strobes let a mirrored level register track us.
//
// Build option: define PWM_AUTO_REPEAT_EN to compile in key auto-repeat
// (PRESSED -> REPEAT after REPEAT_DELAY, then one event every REPEAT_RATE).
// Without it each debounced press yields exactly one event.

// Per-key front end: 2-flop synchroniser, debounce counter and press FSM.
// evt_o is a registered one-cycle event pulse.
module pwm_key_chan #(
  parameter int DEB_CYCLES = 4
`ifdef PWM_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic evt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } key_state_t;

  logic       sync1_q;
  logic       sync2_q;
  logic       deb_q;
  logic       deb_d;
  logic [7:0] deb_cnt_q;
  logic [7:0] deb_cnt_d;
  logic [8:0] deb_cnt_inc;
  logic       deb_rise;
  logic       deb_fall;
  key_state_t state_q;
  logic       evt_q;
`ifdef PWM_AUTO_REPEAT_EN
  logic [15:0] rpt_cnt_q;
  logic [16:0] rpt_inc;
`endif

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples; flip after DEB_CYCLES.
  always_comb begin
    deb_d       = deb_q;
    deb_cnt_d   = 8'd0;
    deb_cnt_inc = {1'b0, deb_cnt_q} + 9'd1;
    if (sync2_q != deb_q) begin
      if (deb_cnt_inc == 9'(DEB_CYCLES)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_inc[7:0];
      end
    end
  end

  assign deb_rise = deb_d & ~deb_q;
  assign deb_fall = ~deb_d & deb_q;

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= 8'd0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

`ifdef PWM_AUTO_REPEAT_EN
  assign rpt_inc = {1'b0, rpt_cnt_q} + 17'd1;
`endif

  // Press FSM; the event is issued on the same edge the debounced state rises,
  // so a clean edge shows up as an event 2 + DEB_CYCLES clocks later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      evt_q     <= 1'b0;
`ifdef PWM_AUTO_REPEAT_EN
      rpt_cnt_q <= 16'd0;
`endif
    end else begin
      evt_q <= 1'b0;
      if (deb_fall) begin
        state_q   <= ST_IDLE;
`ifdef PWM_AUTO_REPEAT_EN
        rpt_cnt_q <= 16'd0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (deb_rise) begin
              state_q   <= ST_PRESSED;
              evt_q     <= 1'b1;
`ifdef PWM_AUTO_REPEAT_EN
              rpt_cnt_q <= 16'd0;
`endif
            end
          end
          ST_PRESSED: begin
`ifdef PWM_AUTO_REPEAT_EN
            if (rpt_inc == 17'(REPEAT_DELAY)) begin
              state_q   <= ST_REPEAT;
              evt_q     <= 1'b1;
              rpt_cnt_q <= 16'd0;
            end else begin
              rpt_cnt_q <= rpt_inc[15:0];
            end
`else
            state_q <= ST_PRESSED;
`endif
          end
          ST_REPEAT: begin
`ifdef PWM_AUTO_REPEAT_EN
            if (rpt_inc == 17'(REPEAT_RATE)) begin
              evt_q     <= 1'b1;
              rpt_cnt_q <= 16'd0;
            end else begin
              rpt_cnt_q <= rpt_inc[15:0];
            end
`else
            state_q <= ST_IDLE;
`endif
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign evt_o = evt_q;

endmodule

// Top: period counter, pending flags, level register and PWM decode.
module pwm_level_ctrl #(
  parameter int MAX_LEVEL    = 10,
  parameter int RESET_LEVEL  = 5,
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic       pwm_out,
  output logic [3:0] level,
  output logic       inc_o,
  output logic       dec_o
);

  localparam logic [3:0] MAX_L = 4'(MAX_LEVEL);
  localparam logic [3:0] RST_L = 4'(RESET_LEVEL);

  logic       evt_inc;
  logic       evt_dec;
  logic       boundary;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] level_q;
  logic [3:0] level_d;
  logic       pend_inc_q;
  logic       pend_inc_d;
  logic       pend_dec_q;
  logic       pend_dec_d;
  logic       inc_q;
  logic       inc_d;
  logic       dec_q;
  logic       dec_d;

  pwm_key_chan #(
    .DEB_CYCLES  (DEB_CYCLES)
`ifdef PWM_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
`endif
  ) u_key_inc (
    .clk    (clk),
    .rst    (rst),
    .key_raw(key_inc),
    .evt_o  (evt_inc)
  );

  pwm_key_chan #(
    .DEB_CYCLES  (DEB_CYCLES)
`ifdef PWM_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
`endif
  ) u_key_dec (
    .clk    (clk),
    .rst    (rst),
    .key_raw(key_dec),
    .evt_o  (evt_dec)
  );

  // Next-state: counter wrap, boundary commit, then re-arm flags from events
  // arriving in the boundary cycle so they are served one period later.
  always_comb begin
    boundary   = (cnt_q == MAX_L);
    cnt_d      = boundary ? 4'd1 : cnt_q + 4'd1;
    level_d    = level_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    pend_inc_d = pend_inc_q | evt_inc;
    pend_dec_d = pend_dec_q | evt_dec;
    if (boundary) begin
      pend_inc_d = evt_inc;
      pend_dec_d = evt_dec;
      if (pend_inc_q && !pend_dec_q) begin
        if (level_q < MAX_L) begin
          level_d = level_q + 4'd1;
          inc_d   = 1'b1;
        end
      end else if (pend_dec_q && !pend_inc_q) begin
        if (level_q != 4'd0) begin
          level_d = level_q - 4'd1;
          dec_d   = 1'b1;
        end
      end
    end
  end

  // Level, counter, pending flags and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      level_q    <= RST_L;
      pend_inc_q <= 1'b0;
      pend_dec_q <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      pend_inc_q <= pend_inc_d;
      pend_dec_q <= pend_dec_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
    end
  end

  // Level 0 is full duty, MAX_LEVEL is off; counter 0 (reset) never drives high.
  assign pwm_out = (cnt_q > level_q);
  assign level   = level_q;
  assign inc_o   = inc_q;
  assign dec_o   = dec_q;

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// Testbench for pwm_level_ctrl (MAX_LEVEL=10, RESET_LEVEL=5, DEB_CYCLES=4).
`timescale 1ns/1ps
module tb_pwm_level_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_inc = 1'b0;
  logic       key_dec = 1'b0;
  logic       pwm_out;
  logic [3:0] level;
  logic       inc_o;
  logic       dec_o;

  int checks = 0;
  int failures = 0;
  int inc_seen = 0;
  int dec_seen = 0;
  int phase = 0;

  typedef struct {
    logic pi;
    logic pd;
    int   exp_level;
    int   exp_inc;
    int   exp_dec;
  } vec_t;

  vec_t vecs[19];
  int   bounce_hi[8];

`ifdef PWM_AUTO_REPEAT_EN
  localparam int HOLD_SINGLE = 12;
  localparam int RPT_LEVEL   = 10;
  localparam int RPT_INCS    = 10;
`else
  localparam int HOLD_SINGLE = 30;
  localparam int RPT_LEVEL   = 1;
  localparam int RPT_INCS    = 1;
`endif

  pwm_level_ctrl #(
    .MAX_LEVEL   (10),
    .RESET_LEVEL (5),
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(16),
    .REPEAT_RATE (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_inc(key_inc),
    .key_dec(key_dec),
    .pwm_out(pwm_out),
    .level  (level),
    .inc_o  (inc_o),
    .dec_o  (dec_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference period counter: 0 in reset, then 1..10 repeating.
  always @(posedge clk or posedge rst) begin
    if (rst) phase <= 0;
    else     phase <= (phase == 10) ? 1 : phase + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: count strobes and require they land right after a boundary.
  always @(negedge clk) begin
    if (!rst) begin
      if (inc_o) begin
        inc_seen++;
        chk("inc_o_at_boundary", phase, 1);
      end
      if (dec_o) begin
        dec_seen++;
        chk("dec_o_at_boundary", phase, 1);
      end
    end
  end

  // driver: press keys for hold cycles, release, then settle
  task automatic press(input logic pi, input logic pd, input int hold);
    key_inc = pi;
    key_dec = pd;
    repeat (hold) @(negedge clk);
    key_inc = 1'b0;
    key_dec = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic pwm_period(input string name, input int exp_hi);
    int hi;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
    chk(name, hi, exp_hi);
  endtask

  task automatic first_period_after_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pwm_first_period", int'(pwm_out), (phase > 5) ? 1 : 0);
    end
  endtask

  initial begin
    int  i0, d0;
    bit  found;

    vecs[0]  = '{1'b1, 1'b0, 7, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 8, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 9, 1, 0};
    vecs[3]  = '{1'b1, 1'b0, 10, 1, 0};
    vecs[4]  = '{1'b1, 1'b0, 10, 0, 0};
    vecs[5]  = '{1'b1, 1'b1, 10, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 9, 0, 1};
    vecs[7]  = '{1'b0, 1'b1, 8, 0, 1};
    vecs[8]  = '{1'b0, 1'b1, 7, 0, 1};
    vecs[9]  = '{1'b0, 1'b1, 6, 0, 1};
    vecs[10] = '{1'b0, 1'b1, 5, 0, 1};
    vecs[11] = '{1'b1, 1'b1, 5, 0, 0};
    vecs[12] = '{1'b0, 1'b1, 4, 0, 1};
    vecs[13] = '{1'b0, 1'b1, 3, 0, 1};
    vecs[14] = '{1'b0, 1'b1, 2, 0, 1};
    vecs[15] = '{1'b0, 1'b1, 1, 0, 1};
    vecs[16] = '{1'b0, 1'b1, 0, 0, 1};
    vecs[17] = '{1'b0, 1'b1, 0, 0, 0};
    vecs[18] = '{1'b1, 1'b1, 0, 0, 0};
    bounce_hi = '{1, 2, 3, 2, 1, 3, 1, 2};

    // Power-on reset.
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_level", int'(level), 5);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_inc_o", int'(inc_o), 0);
    chk("reset_dec_o", int'(dec_o), 0);
    rst = 1'b0;
    first_period_after_reset();

    // Single press.
    i0 = inc_seen;
    d0 = dec_seen;
    press(1'b1, 1'b0, HOLD_SINGLE);
    chk("single_level", int'(level), 6);
    chk("single_inc_count", inc_seen - i0, 1);
    chk("single_dec_count", dec_seen - d0, 0);
    pwm_period("single_pwm_high", 4);

    // Bounce rejection on key_dec.
    d0 = dec_seen;
    for (int p = 0; p < 8; p++) begin
      key_dec = 1'b1;
      repeat (bounce_hi[p]) @(negedge clk);
      key_dec = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("bounce_dec_count", dec_seen - d0, 0);
    chk("bounce_level", int'(level), 6);

    // Table: steps, saturation at both ends, cancellation.
    for (int v = 0; v < 19; v++) begin
      i0 = inc_seen;
      d0 = dec_seen;
      press(vecs[v].pi, vecs[v].pd, 12);
      chk($sformatf("vec%0d_level", v), int'(level), vecs[v].exp_level);
      chk($sformatf("vec%0d_inc", v), inc_seen - i0, vecs[v].exp_inc);
      chk($sformatf("vec%0d_dec", v), dec_seen - d0, vecs[v].exp_dec);
      pwm_period($sformatf("vec%0d_pwm_high", v), 10 - vecs[v].exp_level);
    end

    // Long hold from level 0.
    i0 = inc_seen;
    key_inc = 1'b1;
    repeat (200) @(negedge clk);
    key_inc = 1'b0;
    repeat (40) @(negedge clk);
    chk("hold_level", int'(level), RPT_LEVEL);
    chk("hold_inc_count", inc_seen - i0, RPT_INCS);
    pwm_period("hold_pwm_high", 10 - RPT_LEVEL);

    // Boundary race: align so the dec event lands in the counter==10 cycle.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (phase == 4) found = 1'b1;
    end
    chk("race_align", int'(found), 1);
    d0 = dec_seen;
    key_dec = 1'b1;
    repeat (7) @(negedge clk);
    chk("race_level_p7", int'(level), RPT_LEVEL);
    chk("race_no_dec_p7", dec_seen - d0, 0);
    key_dec = 1'b0;
    repeat (9) @(negedge clk);
    chk("race_level_p16", int'(level), RPT_LEVEL);
    repeat (1) @(negedge clk);
    chk("race_level_p17", int'(level), RPT_LEVEL - 1);
    chk("race_dec_o_p17", int'(dec_o), 1);
    repeat (5) @(negedge clk);
    chk("race_dec_count", dec_seen - d0, 1);

    // Asynchronous reset mid-period.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_level", int'(level), 5);
    chk("midrst_pwm", int'(pwm_out), 0);
    chk("midrst_inc_o", int'(inc_o), 0);
    chk("midrst_dec_o", int'(dec_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    first_period_after_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
